// File: rtl/lsu_mem_responder_pkg.sv
// Shared types for the LSU memory responder: RV32 load/store width codes,
// responder FSM states, byte-enable width and a funct3 legality helper.
package lsu_mem_responder_pkg;

    localparam int BE_W = 4;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } funct3Load;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } funct3Store;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } lsu_state;

    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we) begin
            return !((f3 == SB) || (f3 == SH) || (f3 == SW));
        end
        return !((f3 == LB) || (f3 == LH) || (f3 == LW) ||
                 (f3 == LBU) || (f3 == LHU));
    endfunction

endpackage

// File: rtl/lsu_mem_responder_if.sv
// LSU <-> memory request/response handshake bundle.
// master: LSU side (drives req_*, rsp_ready); slave: memory responder.
interface lsu_mem_responder_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_mem_responder_lane_align.sv
// Byte-lane steering: store byte-enables/replicated data, load extension.
// In: funct3, addr_lo, wdata, rword. Out: be, wdata_al, ldata, misalign.
module lsu_lane_align
    import lsu_mem_responder_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [31:0]     wdata,
    input  logic [31:0]     rword,
    output logic [BE_W-1:0] be,
    output logic [31:0]     wdata_al,
    output logic [31:0]     ldata,
    output logic            misalign
);
    logic [31:0] shifted;
    logic        half;
    logic        word;

    assign shifted = rword >> {addr_lo, 3'b000};
    assign half    = (funct3 == LH) || (funct3 == LHU);
    assign word    = (funct3 == LW);
    assign misalign = (half && addr_lo[0]) || (word && (|addr_lo));

    always_comb begin
        be       = '0;
        wdata_al = '0;
        unique case (1'b1)
            (funct3 == SB): begin
                be       = BE_W'(1) << addr_lo;
                wdata_al = {4{wdata[7:0]}};
            end
            (funct3 == SH): begin
                be       = BE_W'(3) << addr_lo;
                wdata_al = {2{wdata[15:0]}};
            end
            (funct3 == SW): begin
                be       = '1;
                wdata_al = wdata;
            end
            default: begin
                be       = '0;
                wdata_al = '0;
            end
        endcase
    end

    always_comb begin
        ldata = '0;
        unique case (1'b1)
            (funct3 == LB):  ldata = {{24{shifted[7]}}, shifted[7:0]};
            (funct3 == LH):  ldata = {{16{shifted[15]}}, shifted[15:0]};
            (funct3 == LW):  ldata = shifted;
            (funct3 == LBU): ldata = {24'd0, shifted[7:0]};
            (funct3 == LHU): ldata = {16'd0, shifted[15:0]};
            default:         ldata = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_responder.sv
// Memory-side responder for LSU loads/stores over a word-organised RAM.
// Ports: clk, rst_n (async low), bus (slave modport: req_* in, rsp_* out).
module lsu_mem_responder
    import lsu_mem_responder_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    lsu_mem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = 2;

    lsu_state          state_q;
    lsu_state          state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              accept;
    logic              access;

    logic              we_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic [BE_W-1:0]   be;
    logic [31:0]       wdata_al;
    logic [31:0]       ldata;
    logic [31:0]       rword;
    logic              misalign;
    logic              oob;
    logic              err;
    logic              ram_we;
    logic [IDX_W-1:0]  idx;

    logic [31:0]       mem [DEPTH_WORDS];

    assign idx    = addr_q[IDX_W+1:2];
    assign rword  = mem[idx];
    assign oob    = addr_q[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH_WORDS);
    assign err    = f3_illegal(we_q, funct3_q) | misalign | oob;
    assign ram_we = access & we_q & ~err;

    lsu_lane_align u_align (
        .funct3   (funct3_q),
        .addr_lo  (addr_q[1:0]),
        .wdata    (wdata_q),
        .rword    (rword),
        .be       (be),
        .wdata_al (wdata_al),
        .ldata    (ldata),
        .misalign (misalign)
    );

    // Counter starts at LATENCY-1 so the access lands LATENCY edges after
    // acceptance for every legal LATENCY, including 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        access  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    access  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q     <= bus.req_we;
                funct3_q <= bus.req_funct3;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
            end
            if (access) begin
                rdata_q <= (err || we_q) ? '0 : ldata;
                err_q   <= err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata_al[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule
